program_counter: RTL
====================

// Module: program_counter
// PURPOSE
//   Program counter / fetch sequencer for the Program1 core. Sits directly downstream
//   of the branch-target LUT and consumes its 7-bit output (lut_target) as the branch
//   destination. Produces the instruction-memory fetch address. Runs a start/done
//   handshake with the top-level bench and counts retired instructions.
// PARAMETERS
//   PC_W      10   width of pc; all pc arithmetic is modulo 2**PC_W
//   START_PC  0    pc value loaded when a program is started
//   CNT_W     16   width of inst_count; the counter saturates at all-ones
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   start       in   1      one-cycle pulse; begins a program run (IDLE/DONE only)
//   stall       in   1      hold pc, state and counter this cycle
//   halt        in   1      decoded halt instruction at the current pc
//   branch_en   in   1      decoded taken branch at the current pc
//   branch_rel  in   1      1: lut_target is a signed offset; 0: absolute target
//   lut_target  in   7      branch-target LUT output for the current instruction
//   pc          out  PC_W   fetch address (registered)
//   busy        out  1      1 while in RUN (registered)
//   done        out  1      1 while in DONE (registered)
//   inst_count  out  CNT_W  instructions retired in the current run (registered)
// BEHAVIOUR
//   Reset (async, takes effect immediately, including mid-run): state=IDLE, pc=START_PC,
//     busy=0, done=0, inst_count=0.
//   FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
//   IDLE: on start, go to RUN next edge with pc<=START_PC and inst_count<=0. Other inputs
//     are ignored.
//   RUN, per edge, priority stall > halt > branch_en > sequential:
//     stall=1          : pc, state and inst_count hold.
//     halt=1           : state<=DONE; pc holds; inst_count+1 (the halt counts as retired).
//     branch_en & !rel : pc <= zero-extended lut_target; inst_count+1.
//     branch_en &  rel : pc <= pc + sign-extended lut_target (range -64..+63); inst_count+1.
//     otherwise        : pc <= pc+1; inst_count+1.
//     start is ignored in RUN. halt and branch_en in the same cycle: halt wins.
//   DONE: pc and inst_count hold. start begins a new run as in IDLE, with pc<=START_PC and
//     inst_count<=0. done drops on the same edge that busy rises.
//   Width rules: pc+1 and pc+offset wrap modulo 2**PC_W (pc=2**PC_W-1 increments to 0).
//     An absolute target is zero-extended; if PC_W<7, its upper bits are truncated.
//   inst_count saturates at 2**CNT_W-1 and does not wrap.
//   Latency: a branch decision in cycle N is visible on pc after edge N+1. No bubble is
//     inserted here; flush is the decoder's responsibility.
// TESTING
//   1 reset, then start pulse, 5 sequential cycles -> busy=1, pc=0,1,..,5, inst_count=5.
//   2 At pc=3: branch_en=1, branch_rel=0, lut_target=15 -> pc=15 next cycle. Repeat with
//     lut_target=18, then 19 -> pc=18, then pc=19.
//   3 At pc=0: branch_rel=1, lut_target=7'h7F (-1) -> pc=1023 (wrap, PC_W=10). At pc=20:
//     lut_target=7'h05 -> pc=25.
//   4 stall held 3 cycles with branch_en=1 and halt=1 asserted -> pc and inst_count
//     unchanged. Release stall with halt=1 and branch_en=1 -> DONE, done=1, busy=0, pc held,
//     inst_count+1.
//   5 start while in RUN -> ignored. start while in DONE -> pc=0, inst_count=0, busy=1,
//     done=0 on the next edge.
//   6 reset asserted mid-run between clock edges -> pc=0, busy=0, done=0 immediately,
//     without waiting for a clock edge. inst_count forced to 2**CNT_W-1 (CNT_W=4 build)
//     -> it stays at 15 after further instructions.

Source files
------------

// File: rtl/program_counter.sv
// Program counter / fetch sequencer for the Program1 core: IDLE/RUN/DONE control,
// branch-target selection from the LUT output, and a saturating retired-instruction count.
module program_counter #(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             halt,
   input  logic             branch_en,
   input  logic             branch_rel,
   input  logic [6:0]       lut_target,
   output logic [PC_W-1:0]  pc,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] inst_count
);

   // Bit 0 of the state is busy and bit 1 is done, so both outputs come straight from flops.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [PC_W+6:0]  absExt;
   logic [PC_W+6:0]  relExt;
   logic [PC_W-1:0]  branchPc;
   logic [CNT_W-1:0] cntInc;

   // Extending past PC_W and slicing back down covers both truncation and sign extension
   // for any PC_W; the relative add then wraps naturally at the PC width.
   assign absExt   = {{PC_W{1'b0}}, lut_target};
   assign relExt   = {{PC_W{lut_target[6]}}, lut_target};
   assign branchPc = branch_rel ? (pc_q + relExt[PC_W-1:0]) : absExt[PC_W-1:0];
   assign cntInc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (stall) begin
               state_d = RUN;
            end else if (halt) begin
               state_d = DONE;
               cnt_d   = cntInc;
            end else if (branch_en) begin
               pc_d  = branchPc;
               cnt_d = cntInc;
            end else begin
               pc_d  = pc_q + 1'b1;
               cnt_d = cntInc;
            end
         end
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_PC;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc         = pc_q;
   assign busy       = state_q[0];
   assign done       = state_q[1];
   assign inst_count = cnt_q;

endmodule
